// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants the core (port 0) or the loader (port 1) one
// single-ported data-memory transaction at a time and returns the response.
// Ports: clk, rst_n (async, active low); pX_req_valid/ready, pX_we, pX_addr,
//   pX_wdata (request side); pX_rsp_valid/ready, pX_rdata, pX_rsp_err
//   (response side); mem_addr, mem_wdata, mem_read, mem_write, mem_rdata.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on a
//   simultaneous request; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int DEPTH = 24,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_rsp_valid,
    input  logic          p0_rsp_ready,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_rsp_err,
    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_rsp_valid,
    input  logic          p1_rsp_ready,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_rsp_err,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_id;
    logic          r_we;
    logic          r_oor;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [31:0]   r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_idle;
    logic          w_pref1;
    logic          w_pick1;
    logic          w_accept;
    logic          w_sel_we;
    logic [31:0]   w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_in_range;
    logic          w_rsp_ack;
    logic          w_rsp0;
    logic          w_rsp1;

`ifdef DMEM_ARB_RR_EN
    // r_ptr = 1 means port 1 wins the next tie
    logic r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_pick1;
        end
    end

    assign w_pref1 = r_ptr;
`else
    assign w_pref1 = 1'b0;
`endif

    assign w_idle      = (r_state == IDLE);
    assign w_pick1     = p1_req_valid & (~p0_req_valid | w_pref1);
    assign w_accept    = w_idle & (p0_req_valid | p1_req_valid);
    assign w_sel_we    = w_pick1 ? p1_we : p0_we;
    assign w_sel_addr  = w_pick1 ? p1_addr : p0_addr;
    assign w_sel_wdata = w_pick1 ? p1_wdata : p0_wdata;
    assign w_in_range  = (w_sel_addr < 32'(DEPTH));
    assign w_rsp_ack   = r_id ? p1_rsp_ready : p0_rsp_ready;

    assign p0_req_ready = w_idle & p0_req_valid & ~w_pick1;
    assign p1_req_ready = w_idle & w_pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    if (w_rsp_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are loaded on accept so they are high exactly in ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_accept) begin
                r_id  <= w_pick1;
                r_we  <= w_sel_we;
                r_oor <= ~w_in_range;
                if (w_in_range) begin
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_wdata;
                    r_mem_read  <= ~w_sel_we;
                    r_mem_write <= w_sel_we;
                end
            end
            if (r_state == ACCESS) begin
                r_err   <= r_oor;
                r_rdata <= (!r_oor && !r_we) ? mem_rdata : '0;
            end
        end
    end

    assign w_rsp0 = (r_state == RESP) & ~r_id;
    assign w_rsp1 = (r_state == RESP) & r_id;

    assign p0_rsp_valid = w_rsp0;
    assign p1_rsp_valid = w_rsp1;
    assign p0_rdata     = w_rsp0 ? r_rdata : '0;
    assign p1_rdata     = w_rsp1 ? r_rdata : '0;
    assign p0_rsp_err   = w_rsp0 & r_err;
    assign p1_rsp_err   = w_rsp1 & r_err;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model with a
// behavioural memory, directed scenarios and a randomized phase.
module tb_dmem_arbiter;

    localparam int DEPTH = 24;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    v;
    logic [1:0]    we;
    logic [1:0]    rr;
    logic [31:0]   a  [2];
    logic [DW-1:0] wd [2];

    logic          p0_req_ready, p1_req_ready;
    logic          p0_rsp_valid, p1_rsp_valid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_rsp_err, p1_rsp_err;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req_valid (v[0]),
        .p0_req_ready (p0_req_ready),
        .p0_we        (we[0]),
        .p0_addr      (a[0]),
        .p0_wdata     (wd[0]),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (rr[0]),
        .p0_rdata     (p0_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (v[1]),
        .p1_req_ready (p1_req_ready),
        .p1_we        (we[1]),
        .p1_addr      (a[1]),
        .p1_wdata     (wd[1]),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (rr[1]),
        .p1_rdata     (p1_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    // memory seen by the DUT, and the model's own view of its contents
    logic [DW-1:0] dm      [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    assign mem_rdata = (mem_read && mem_addr < DEPTH) ? dm[mem_addr[4:0]]
                                                      : 32'hBAD0_F00D;

    always @(posedge clk) begin
        if (mem_write && mem_addr < DEPTH) dm[mem_addr[4:0]] <= mem_wdata;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    bit            busy = 0;
    int            bp = 0;
    bit            bwe, berr;
    logic [31:0]   baddr;
    logic [DW-1:0] bwd, brd, bold;
    int            acc = 0;
    int            cyc = 0;
    int            last_w = 1;
    logic [1:0]    took = 2'b00;
    int            rsp_cnt [2] = '{0, 0};
    int            rsp_cyc [2] = '{0, 0};
    int            acc_cyc [2] = '{0, 0};
    logic [DW-1:0] last_rd [2];
    logic          last_err [2];
    int            grants [$];
    int            strobes = 0;
    int            p1_seen = 0;

    bit            m_wb, m_on, m_erd, m_ewr;
    int            m_ew;
    logic [1:0]    m_er, m_erv;

    always @(negedge clk) begin
        cyc++;
        took = {p1_req_ready & v[1], p0_req_ready & v[0]};
        if (p1_req_ready) p1_seen++;
        if (!rst_n) begin
            // a write cut off before its strobe edge never lands
            if (busy && bwe && !berr && cyc <= acc + 1)
                ref_mem[baddr[4:0]] = bold;
            busy = 0;
            last_w = 1;
            took = 2'b00;
            chk("rst_req_ready", 64'({p1_req_ready, p0_req_ready}), 64'(0));
            chk("rst_rsp_valid", 64'({p1_rsp_valid, p0_rsp_valid}), 64'(0));
            chk("rst_rsp_err", 64'({p1_rsp_err, p0_rsp_err}), 64'(0));
            chk("rst_rdata", 64'(p0_rdata | p1_rdata), 64'(0));
            chk("rst_strobe", 64'({mem_read, mem_write}), 64'(0));
            chk("rst_mem_bus", 64'(mem_addr | mem_wdata), 64'(0));
        end else begin
            m_wb = busy;
            m_erd = busy && cyc == acc + 1 && !berr && !bwe;
            m_ewr = busy && cyc == acc + 1 && !berr && bwe;
            chk("mem_read", 64'(mem_read), 64'(m_erd));
            chk("mem_write", 64'(mem_write), 64'(m_ewr));
            if (mem_read || mem_write) strobes++;
            if (m_erd || m_ewr) chk("mem_addr", 64'(mem_addr), 64'(baddr));
            if (m_ewr) chk("mem_wdata", 64'(mem_wdata), 64'(bwd));

            m_on = busy && cyc >= acc + 2;
            m_erv = m_on ? (bp == 1 ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", 64'({p1_rsp_valid, p0_rsp_valid}), 64'(m_erv));
            chk("rdata0", 64'(p0_rdata), 64'(m_erv[0] ? brd : '0));
            chk("rdata1", 64'(p1_rdata), 64'(m_erv[1] ? brd : '0));
            chk("rsp_err", 64'({p1_rsp_err, p0_rsp_err}),
                64'(berr ? m_erv : 2'b00));
            if (m_on && rr[bp]) begin
                busy = 0;
                rsp_cnt[bp]++;
                rsp_cyc[bp] = cyc;
                last_rd[bp] = (bp == 1) ? p1_rdata : p0_rdata;
                last_err[bp] = (bp == 1) ? p1_rsp_err : p0_rsp_err;
            end

            m_er = 2'b00;
            if (!m_wb && v != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
                m_ew = (v == 2'b11) ? (last_w == 0 ? 1 : 0) : (v[1] ? 1 : 0);
`else
                m_ew = v[0] ? 0 : 1;
`endif
                m_er = (m_ew == 1) ? 2'b10 : 2'b01;
            end
            chk("req_ready", 64'({p1_req_ready, p0_req_ready}), 64'(m_er));
            if (m_er != 2'b00) begin
                busy = 1;
                bp = m_ew;
                bwe = we[m_ew];
                baddr = a[m_ew];
                bwd = wd[m_ew];
                berr = a[m_ew] >= DEPTH;
                acc = cyc;
                acc_cyc[m_ew] = cyc;
                brd = (berr || bwe) ? '0 : ref_mem[baddr[4:0]];
                if (!berr && bwe) begin
                    bold = ref_mem[baddr[4:0]];
                    ref_mem[baddr[4:0]] = bwd;
                end
                last_w = m_ew;
                grants.push_back(m_ew);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] auto = 2'b00;
    int         rate = 0;
    bit         rand_rr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (took[p]) v[p] = 1'b0;
            if (auto[p] && !v[p] && $urandom_range(0, 99) < rate) begin
                v[p] = 1'b1;
                we[p] = 1'($urandom_range(0, 1));
                a[p] = 32'($urandom_range(0, DEPTH + 3));
                wd[p] = $urandom;
            end
            if (rand_rr) rr[p] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic req(input int p, input bit w, input logic [31:0] ad,
                       input logic [DW-1:0] d);
        v[p] = 1'b1;
        we[p] = w;
        a[p] = ad;
        wd[p] = d;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!v[p]) return;
        end
        chk("req_timeout", 64'(0), 64'(1));
        v[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int p, input int n0);
        for (int i = 0; i < 40; i++) begin
            if (rsp_cnt[p] != n0) return;
            tick();
        end
        chk("rsp_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (v == 2'b00 && !busy) return;
            tick();
        end
        chk("drain_timeout", 64'(0), 64'(1));
    endtask

    int            n, s0, g0, ps0;
    logic [DW-1:0] held, pre;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dm[i] = $urandom;
            ref_mem[i] = dm[i];
        end
        v = 2'b00;
        we = 2'b00;
        rr = 2'b11;
        a[0] = '0; a[1] = '0;
        wd[0] = '0; wd[1] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // write then read address 5 from port 0
        s0 = strobes;
        n = rsp_cnt[0];
        req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        wait_rsp(0, n);
        chk("wr_rdata", 64'(last_rd[0]), 64'(0));
        chk("wr_err", 64'(last_err[0]), 64'(0));
        chk("wr_strobes", 64'(strobes - s0), 64'(1));
        n = rsp_cnt[0];
        req(0, 1'b0, 32'd5, 32'h0);
        wait_rsp(0, n);
        chk("rd5_data", 64'(last_rd[0]), 64'(32'hDEAD_BEEF));
        chk("rd5_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(2));
        tick();

        // both ports request back to back
        g0 = grants.size();
        ps0 = p1_seen;
        rate = 100;
        auto = 2'b11;
        repeat (16) tick();
        auto = 2'b00;
        chk("both_count", 64'(grants.size() >= g0 + 5), 64'(1));
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 4; i++)
            chk("rr_alt", 64'(grants[g0 + i + 1]), 64'(grants[g0 + i] ^ 1));
`else
        for (int i = 0; i < 4; i++)
            chk("fix_prio", 64'(grants[g0 + i]), 64'(0));
        chk("p1_starve", 64'(p1_seen - ps0), 64'(0));
`endif
        drain();

        // out of range read from port 1
        s0 = strobes;
        n = rsp_cnt[1];
        req(1, 1'b0, 32'd24, 32'h0);
        wait_rsp(1, n);
        chk("oor_err", 64'(last_err[1]), 64'(1));
        chk("oor_rdata", 64'(last_rd[1]), 64'(0));
        chk("oor_strobe", 64'(strobes - s0), 64'(0));
        tick();

        // backpressure on port 0 with port 1 waiting
        rr[0] = 1'b0;
        n = rsp_cnt[0];
        req(0, 1'b0, 32'd3, 32'h0);
        tick();
        v[1] = 1'b1;
        we[1] = 1'b0;
        a[1] = 32'd9;
        held = p0_rdata;
        chk("bp_first", 64'(held), 64'(ref_mem[3]));
        repeat (5) begin
            tick();
            chk("bp_valid", 64'(p0_rsp_valid), 64'(1));
            chk("bp_hold", 64'(p0_rdata), 64'(held));
            chk("bp_p1_ready", 64'(p1_req_ready), 64'(0));
        end
        rr[0] = 1'b1;
        for (int i = 0; i < 10 && v[1]; i++) tick();
        chk("bp_gap", 64'(acc_cyc[1] - rsp_cyc[0]), 64'(1));
        drain();

        // reset in the middle of a write
        pre = ref_mem[7];
        n = rsp_cnt[0];
        req(0, 1'b1, 32'd7, 32'h1234_5678);
        chk("rst_wr_pre", 64'(mem_write), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_wr_drop", 64'(mem_write), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_rsp", 64'(rsp_cnt[0] - n), 64'(0));
        n = rsp_cnt[1];
        req(1, 1'b0, 32'd7, 32'h0);
        wait_rsp(1, n);
        chk("rst_after", 64'(last_rd[1]), 64'(pre));
        tick();

        // randomized traffic
        rate = 40;
        rand_rr = 1;
        auto = 2'b11;
        repeat (1500) tick();
        auto = 2'b00;
        rand_rr = 0;
        rr = 2'b11;
        drain();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
